// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer in front of a
//            single-port memory that reads and writes on the falling clock
//            edge. Each requester holds a request until it receives a
//            one-cycle done pulse. The memory write strobe (active-low
//            readwriteN) is low for exactly one falling edge per write.
// Ports    : clk, resetN (async, active-low)
//            req0/rwN0/addr0/wdata0 -> gnt0/done0/rdata0  (requester 0)
//            req1/rwN1/addr1/wdata1 -> gnt1/done1/rdata1  (requester 1)
//            mem_readwriteN/mem_address/mem_data_in -> memory
//            mem_data_out <- memory
//            busy : high while an access is in ACCESS or DONE
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req0,
  input  logic              rwN0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              rwN1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_readwriteN,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              mem_rwn_q, mem_rwn_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;

  // Arbitration: a lone request wins; on a tie the port that was not served
  // last wins. arb_win = 1 selects port 1.
  logic arb_req;
  logic arb_win;

  always_comb begin
    arb_req = req0 | req1;
    arb_win = (req0 & req1) ? ~last_q : req1;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    mem_rwn_d  = mem_rwn_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    done0_d    = done0_q;
    done1_d    = done1_q;

    case (state_q)
      // DONE re-arbitrates exactly like IDLE so back-to-back accesses take
      // two cycles each.
      ST_IDLE, ST_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        state_d = ST_IDLE;
        if (arb_req) begin
          state_d    = ST_ACCESS;
          last_d     = arb_win;
          gnt0_d     = ~arb_win;
          gnt1_d     = arb_win;
          mem_addr_d = arb_win ? addr1  : addr0;
          mem_din_d  = arb_win ? wdata1 : wdata0;
          mem_rwn_d  = arb_win ? rwN1   : rwN0;
        end
      end
      ST_ACCESS: begin
        // The memory acted on the falling edge inside this cycle; release
        // the write strobe so it covers exactly one falling edge.
        state_d   = ST_DONE;
        mem_rwn_d = 1'b1;
        if (mem_rwn_q) begin
          if (gnt1_q) rdata1_d = mem_data_out;
          else        rdata0_d = mem_data_out;
        end
        done0_d = gnt0_q;
        done1_d = gnt1_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      mem_rwn_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      mem_rwn_q  <= mem_rwn_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
    end
  end

  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_readwriteN = mem_rwn_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_in    = mem_din_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire
